adc_ads85x8_ctrl: RTL and testbench

ADC_ADS85X8_CTRL -- requirements
Module: adc_ads85x8_ctrl

---
 rtl/adc_ads85x8_ctrl.sv | 168 ++++++++++++++++
 tb/tb_adc_ads85x8_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ads85x8_ctrl.sv
// ADS85x8 parallel-bus controller: writes two config words, then reads NUM_CH samples per tick to AXI-Stream.
// Define ADC_CTRL_OVERRUN_CNT_EN to add the overrun_cnt port counting ticks dropped mid-frame.
module adc_ads85x8_ctrl #(
    parameter int          DATA_W       = 16,
    parameter int          NUM_CH       = 8,
    parameter int          SAMPLE_DIV   = 1000,
    parameter logic [15:0] CFG_WORD_0   = 16'h8054,
    parameter logic [15:0] CFG_WORD_1   = 16'h43FF,
    parameter int          BUSY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        sreset,
    input  logic        enable,
    input  logic        busy,
    inout  wire  [15:0] data_adc,
    output logic        read_n,
    output logic        write_n,
    output logic        chipselect_n,
    output logic        software_mode,
    output logic        serial_mode,
    output logic        standby_n,
    output logic        conv_start_a,
    output logic        conv_start_b,
    output logic        conv_start_c,
    output logic        conv_start_d,
    output logic [15:0] m_tdata,
    output logic [2:0]  m_tuser,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        timeout_err
`ifdef ADC_CTRL_OVERRUN_CNT_EN
    ,
    output logic [15:0] overrun_cnt
`endif
);

    localparam int TW = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {
        S_CFG_WR,
        S_CFG_GAP,
        S_IDLE,
        S_CONV,
        S_WAIT_BUSY,
        S_READ,
        S_HOLD
    } state_t;

    state_t        r_state;
    logic          r_cfg_pass;
    logic [2:0]    r_ch;
    logic [TW-1:0] r_tick_cnt;
    logic [15:0]   r_wait;

    logic          w_tick;
    logic          w_last;
    logic          w_conv_start;
    logic [15:0]   w_sample;
    logic          w_unused_bits;

    assign w_tick   = (r_tick_cnt == TW'(SAMPLE_DIV - 1));
    assign w_last   = (r_ch == 3'(NUM_CH - 1));
    assign w_sample = 16'($signed(data_adc[DATA_W-1:0]));
    assign w_unused_bits = ^data_adc;

    // Strobes are forced inactive combinationally while sreset is high.
    assign write_n      = sreset | (r_state != S_CFG_WR);
    assign read_n       = sreset | (r_state != S_READ);
    assign chipselect_n = sreset;
    assign w_conv_start = ~sreset & (r_state == S_CONV);

    assign data_adc = write_n ? 16'hzzzz
                    : (r_cfg_pass ? CFG_WORD_1 : CFG_WORD_0);

    assign conv_start_a  = w_conv_start;
    assign conv_start_b  = w_conv_start;
    assign conv_start_c  = w_conv_start;
    assign conv_start_d  = w_conv_start;
    assign software_mode = 1'b1;
    assign serial_mode   = 1'b0;
    assign standby_n     = 1'b1;

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state     <= S_CFG_WR;
            r_cfg_pass  <= 1'b0;
            r_ch        <= '0;
            r_tick_cnt  <= '0;
            r_wait      <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tdata     <= '0;
            m_tuser     <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            unique case (r_state)
                S_CFG_WR: r_state <= S_CFG_GAP;
                S_CFG_GAP: begin
                    r_cfg_pass <= 1'b1;
                    r_state    <= r_cfg_pass ? S_IDLE : S_CFG_WR;
                end
                S_IDLE: begin
                    if (w_tick && enable) begin
                        r_ch    <= '0;
                        r_wait  <= '0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (busy) begin
                        r_wait  <= '0;
                        r_state <= S_WAIT_BUSY;
                    end else if (r_wait == 16'd15) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!busy) begin
                        r_state <= S_READ;
                    end else if (r_wait == 16'(BUSY_TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_READ: begin
                    m_tdata  <= w_sample;
                    m_tuser  <= r_ch;
                    m_tlast  <= w_last;
                    m_tvalid <= 1'b1;
                    r_state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (m_tready) begin
                        m_tvalid <= 1'b0;
                        m_tdata  <= '0;
                        if (m_tlast) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_ch    <= r_ch + 3'd1;
                            r_state <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ADC_CTRL_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (sreset) begin
            overrun_cnt <= '0;
        end else if (w_tick && r_state != S_IDLE && overrun_cnt != 16'hFFFF) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`else
    // Ticks arriving mid-frame are discarded without being recorded.
`endif

endmodule

// File: tb/tb_adc_ads85x8_ctrl.sv
// Bench for adc_ads85x8_ctrl: event-scheduled model of the ADC frame timing plus pinned literal checks.
`timescale 1ns/1ps
module tb_adc_ads85x8_ctrl;

    localparam int DW    = 12;
    localparam int NCH   = 8;
    localparam int SDIV  = 64;
    localparam int BTO   = 255;
    localparam int NEVER = 32'h3fffffff;

    logic clk = 1'b0;
    logic sreset = 1'b1;
    logic enable = 1'b0;
    logic busy = 1'b0;
    logic m_tready = 1'b0;
    wire  [15:0] data_adc;
    logic read_n, write_n, chipselect_n;
    logic software_mode, serial_mode, standby_n;
    logic conv_start_a, conv_start_b, conv_start_c, conv_start_d;
    logic [15:0] m_tdata;
    logic [2:0]  m_tuser;
    logic m_tlast, m_tvalid, timeout_err;
`ifdef ADC_CTRL_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt;
`endif

    logic [15:0] adc_drv;
    assign data_adc = (read_n == 1'b0) ? adc_drv : 16'hzzzz;

    adc_ads85x8_ctrl #(
        .DATA_W(DW), .NUM_CH(NCH), .SAMPLE_DIV(SDIV),
        .CFG_WORD_0(16'h8054), .CFG_WORD_1(16'h43FF), .BUSY_TIMEOUT(BTO)
    ) dut (
        .clk(clk), .sreset(sreset), .enable(enable), .busy(busy),
        .data_adc(data_adc), .read_n(read_n), .write_n(write_n),
        .chipselect_n(chipselect_n), .software_mode(software_mode),
        .serial_mode(serial_mode), .standby_n(standby_n),
        .conv_start_a(conv_start_a), .conv_start_b(conv_start_b),
        .conv_start_c(conv_start_c), .conv_start_d(conv_start_d),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .timeout_err(timeout_err)
`ifdef ADC_CTRL_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model state: cycle index since reset release and the current frame's schedule.
    int c = -1;
    bit live = 1'b0;
    bit fr, conv_to, to_err, rand_frames, n_cto;
    int t_c, cs_end, bz_s, bz_e, end_c, nvalid, idx, ovr;
    int n_D, n_L, scen;
    logic [15:0] adc_val [8];

    bit e_wn, e_rn, e_cs, e_valid, e_last, e_to;
    logic [15:0] e_wdata, e_data, e_ovr;
    logic [2:0] e_user;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, c);
        end
    endtask

    function automatic logic [15:0] sext(input logic [15:0] v);
        int x;
        x = int'(v) % (1 << DW);
        if (x >= (1 << (DW - 1))) x = x - (1 << DW);
        return 16'(x);
    endfunction

    task automatic model_reset();
        c = 0; fr = 0; conv_to = 0; to_err = 0; ovr = 0; idx = 0;
        t_c = NEVER; cs_end = NEVER; bz_s = NEVER; bz_e = NEVER;
        end_c = NEVER; nvalid = NEVER;
    endtask

    task automatic eval();
        e_wn    = !(c == 0 || c == 2);
        e_wdata = (c == 0) ? 16'h8054 : 16'h43FF;
        busy    = (c >= bz_s) && (c < bz_e);
        e_cs    = fr && (c >= t_c) && (c <= cs_end);
        e_valid = fr && (c >= nvalid);
        e_rn    = !(fr && (c == nvalid - 1));
        e_user  = 3'(idx);
        e_last  = (idx == NCH - 1);
        e_data  = e_valid ? sext(adc_val[idx]) : 16'h0000;
        adc_drv = adc_val[idx];
        e_to    = to_err;
        e_ovr   = 16'(ovr);
    endtask

    task automatic start_frame();
        fr = 1; t_c = c + 1; idx = 0;
        if (rand_frames) begin
            for (int k = 0; k < 8; k++) adc_val[k] = 16'($urandom);
            n_D   = $urandom_range(0, 5);
            n_L   = $urandom_range(1, 40);
            n_cto = ($urandom_range(0, 15) == 0);
        end
        conv_to = n_cto;
        if (conv_to) begin
            cs_end = t_c + 15; end_c = t_c + 16; nvalid = NEVER;
            bz_s = NEVER; bz_e = NEVER;
        end else begin
            bz_s = t_c + 1 + n_D; bz_e = bz_s + n_L; cs_end = bz_s;
            if (n_L - 1 > BTO) begin
                end_c = bz_s + BTO + 2; nvalid = NEVER;
            end else begin
                end_c = NEVER; nvalid = bz_s + n_L + 2;
            end
        end
    endtask

    task automatic advance();
        bit tk, idle;
        tk   = ((c + 1) % SDIV) == 0;
        idle = (c >= 4) && !fr;
        if (tk) begin
            if (idle && enable) start_frame();
            else if (!idle && ovr < 65535) ovr++;
        end
        if (e_valid && m_tready) begin
            if (idx == NCH - 1) fr = 0;
            else begin idx++; nvalid = c + 2; end
        end
        if (fr && c + 1 == end_c) begin fr = 0; to_err = 1; end
        c++;
    endtask

    always @(negedge clk) begin
        if (sreset) begin
            chk("rst_strobes", {write_n, read_n, chipselect_n}, 3'b111);
            chk("rst_conv", {conv_start_a, conv_start_b, conv_start_c, conv_start_d}, 4'b0);
        end else if (live) begin
            chk("ties", {software_mode, serial_mode, standby_n}, 3'b101);
            chk("chipselect_n", chipselect_n, 1'b0);
            chk("write_n", write_n, e_wn);
            if (!e_wn) chk("cfg_word", data_adc, e_wdata);
            chk("read_n", read_n, e_rn);
            chk("conv_start", {conv_start_a, conv_start_b, conv_start_c, conv_start_d}, {4{e_cs}});
            chk("m_tvalid", m_tvalid, e_valid);
            chk("m_tdata", m_tdata, e_data);
            if (e_valid) chk("m_tuser_tlast", {m_tuser, m_tlast}, {e_user, e_last});
            chk("timeout_err", timeout_err, e_to);
`ifdef ADC_CTRL_OVERRUN_CNT_EN
            chk("overrun_cnt", overrun_cnt, e_ovr);
`endif
        end
    end

    task automatic pins();
        if (scen == 1 && c == 63) chk("pin_no_conv_before_tick", conv_start_a, 1'b0);
        if (scen == 1 && c == 64) chk("pin_first_conv", conv_start_a, 1'b1);
        if (scen == 1 && c == 87) chk("pin_sext_F800", {m_tvalid, m_tuser, m_tdata}, {1'b1, 3'd0, 16'hF800});
        if (scen == 1 && c == 150) chk("pin_stall_beat3", {m_tvalid, m_tuser, m_tdata}, {1'b1, 3'd3, 16'h07FF});
        if (scen == 1 && c == 300) chk("pin_gap_before_last", m_tvalid, 1'b0);
        if (scen == 1 && c == 301) chk("pin_last_beat", {m_tvalid, m_tuser, m_tlast}, {1'b1, 3'd7, 1'b1});
`ifdef ADC_CTRL_OVERRUN_CNT_EN
        if (scen == 1 && c == 330) chk("pin_overrun_3", overrun_cnt, 16'd3);
`endif
        if (scen == 2 && c == 321) chk("pin_stuck_pre", timeout_err, 1'b0);
        if (scen == 2 && c == 322) chk("pin_stuck_timeout", {timeout_err, m_tvalid}, 2'b10);
        if (scen == 2 && c == 384) chk("pin_restart_conv", conv_start_a, 1'b1);
        if (scen == 2 && c == 407) chk("pin_restart_beat", {m_tvalid, m_tuser}, {1'b1, 3'd0});
        if (scen == 3 && c == 79) chk("pin_conv_hold", conv_start_a, 1'b1);
        if (scen == 3 && c == 80) chk("pin_conv_timeout", {timeout_err, conv_start_a}, 2'b10);
    endtask

    task automatic run_cycle(input logic en, input logic rdy);
        enable = en;
        m_tready = rdy;
        eval();
        live = 1'b1;
        @(negedge clk);
        pins();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic do_reset(input int n);
        sreset = 1'b1;
        live = 1'b0;
        busy = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        sreset = 1'b0;
        model_reset();
    endtask

    initial begin
        rand_frames = 0; n_cto = 0; n_D = 0; n_L = 20; scen = 1;
        adc_val[0] = 16'h0800; adc_val[1] = 16'h0123;
        adc_val[2] = 16'h0FFF; adc_val[3] = 16'hA7FF;
        adc_val[4] = 16'h0001; adc_val[5] = 16'h0C00;
        adc_val[6] = 16'h0400; adc_val[7] = 16'h07FE;
        do_reset(2);
        for (int i = 0; i < 350; i++) run_cycle(1'b1, !(c >= 93 && c < 293));

        scen = 2; n_L = 300;
        do_reset(1);
        for (int i = 0; i < 430; i++) begin
            if (c == 200) n_L = 20;
            run_cycle(1'b1, 1'b1);
        end

        scen = 3; n_cto = 1;
        do_reset(1);
        for (int i = 0; i < 120; i++) run_cycle(1'b1, 1'b1);

        scen = 4; n_cto = 0; rand_frames = 1;
        do_reset(1);
        for (int i = 0; i < 2000; i++)
            run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
        do_reset(1);
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
